// File: rtl/shift_sched.sv
// Round-robin scheduler sharing one parallel-to-serial shift engine among NREQ requesters.
// Grants one word at a time, strobes it into the shifter and waits for end-of-shift or timeout.
module shift_sched #(
    parameter int unsigned BITS = 8,
    parameter int unsigned NREQ = 4,
    parameter int unsigned TMO  = BITS + 2,
    localparam int unsigned IDW = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*BITS-1:0] data,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic                 busy,
    output logic [IDW-1:0]       cur_id,
    output logic                 sh_load,
    output logic [BITS-1:0]      sh_data,
    input  logic                 sh_eos
);

    localparam int unsigned CW = $clog2(TMO + 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StGap
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [IDW-1:0]  last_q;

    logic            found;
    logic [IDW-1:0]  winner;
    logic [IDW-1:0]  cand;
    logic [BITS-1:0] win_word;

    function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
        logic [NREQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Search upward from the requester after the last winner, wrapping, so the most
    // recently served requester is considered last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IDW'((32'(last_q) + i) % NREQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        win_word = data[winner*BITS +: BITS];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            last_q  <= IDW'(NREQ - 1);
            ack     <= '0;
            done    <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
            cur_id  <= '0;
            sh_load <= 1'b0;
            sh_data <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        state_q <= StLoad;
                        sh_load <= 1'b1;
                        ack     <= onehot(winner);
                        sh_data <= win_word;
                        cur_id  <= winner;
                        last_q  <= winner;
                        busy    <= 1'b1;
                    end
                end
                StLoad: begin
                    sh_load <= 1'b0;
                    ack     <= '0;
                    cnt_q   <= '0;
                    state_q <= StShift;
                end
                StShift: begin
                    cnt_q <= cnt_q + 1'b1;
                    // End-of-shift takes precedence over a timeout in the same cycle.
                    if (sh_eos) begin
                        done    <= onehot(cur_id);
                        state_q <= StGap;
                    end else if (cnt_q == CW'(TMO - 1)) begin
                        err     <= 1'b1;
                        state_q <= StGap;
                    end
                end
                StGap: begin
                    done    <= '0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sched.sv
// Directed bench for shift_sched: reset, single word, round-robin, wrap/skip, watchdog,
// eos/timeout collision and mid-transfer reset.
module tb_shift_sched;

    localparam int BITS = 8;
    localparam int NREQ = 4;
    localparam int TMO  = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic [NREQ-1:0]  req;
    logic [NREQ*BITS-1:0] data;
    logic [NREQ-1:0]  ack;
    logic [NREQ-1:0]  done;
    logic             err;
    logic             busy;
    logic [1:0]       cur_id;
    logic             sh_load;
    logic [BITS-1:0]  sh_data;
    logic             sh_eos;

    int checks = 0;
    int errors = 0;

    shift_sched #(.BITS(BITS), .NREQ(NREQ), .TMO(TMO)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .data    (data),
        .ack     (ack),
        .done    (done),
        .err     (err),
        .busy    (busy),
        .cur_id  (cur_id),
        .sh_load (sh_load),
        .sh_data (sh_data),
        .sh_eos  (sh_eos)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst    = 1'b1;
        req    = '0;
        sh_eos = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Waits for sh_load; waited=1 means LOAD in the cycle right after the request cycle.
    task automatic wait_grant(input int limit, output int waited, output logic [1:0] id,
                              output logic [7:0] word, output logic [3:0] ackv);
        waited = -1;
        id     = '0;
        word   = '0;
        ackv   = '0;
        for (int c = 1; c <= limit; c++) begin
            tick();
            if (sh_load) begin
                waited = c;
                id     = cur_id;
                word   = sh_data;
                ackv   = ack;
                break;
            end
        end
    endtask

    // Called in the LOAD cycle; iteration c samples SHIFT cycle c. eos_at=0 never raises eos.
    task automatic finish_word(input int eos_at, output logic [3:0] done_vec,
                               output int done_cyc, output int n_done, output int n_err,
                               output int err_cyc, output int idle_cyc, output int n_ack);
        done_vec = '0;
        done_cyc = -1;
        n_done   = 0;
        n_err    = 0;
        err_cyc  = -1;
        idle_cyc = -1;
        n_ack    = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (|done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    done_vec = done;
                end
            end
            if (err) begin
                n_err++;
                if (err_cyc < 0) err_cyc = c;
            end
            if (|ack || sh_load) n_ack++;
            if (!busy) begin
                idle_cyc = c;
                break;
            end
            sh_eos = (c == eos_at);
        end
        sh_eos = 1'b0;
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        req    = 4'b1111;
        data   = 32'h44332211;
        sh_eos = 1'b1;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (sh_load !== 1'b0) begin errors++; $display("FAIL reset_load got %b want 0", sh_load); end
        checks++; if ({ack, done, err} !== 9'b0) begin errors++;
            $display("FAIL reset_pulses got %b want 0", {ack, done, err}); end
        checks++; if (sh_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", sh_data); end
        checks++; if (cur_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d want 0", cur_id); end
        rst    = 1'b0;
        req    = '0;
        sh_eos = 1'b0;
        tick();
    endtask

    task automatic test_single;
        int w, dc, nd, ne, ec, ic, na;
        logic [1:0] id;
        logic [7:0] word;
        logic [3:0] av, dv;
        do_reset();
        data = 32'h000000A5;
        req  = 4'b0001;
        wait_grant(4, w, id, word, av);
        req = '0;
        checks++; if (w !== 1) begin errors++; $display("FAIL single_latency got %0d want 1", w); end
        checks++; if (word !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", word); end
        checks++; if (av !== 4'b0001) begin errors++; $display("FAIL single_ack got %b want 0001", av); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_load got %b want 1", busy); end
        finish_word(8, dv, dc, nd, ne, ec, ic, na);
        checks++; if (dc !== 9) begin errors++; $display("FAIL single_done_cycle got %0d want 9", dc); end
        checks++; if (dv !== 4'b0001) begin errors++; $display("FAIL single_done_vec got %b want 0001", dv); end
        checks++; if (nd !== 1 || ne !== 0) begin errors++;
            $display("FAIL single_counts got done=%0d err=%0d want 1/0", nd, ne); end
        checks++; if (ic !== 10) begin errors++; $display("FAIL single_idle_cycle got %0d want 10", ic); end
        checks++; if (na !== 0) begin errors++; $display("FAIL single_ack_width got %0d want 0", na); end
    endtask

    task automatic test_round_robin;
        int w, dc, nd, ne, ec, ic, na;
        logic [1:0] id;
        logic [7:0] word;
        logic [3:0] av, dv;
        do_reset();
        data = 32'h44332211;
        req  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(6, w, id, word, av);
            checks++; if (w !== 1 || id !== 2'(k % 4)) begin errors++;
                $display("FAIL rr_grant%0d got id=%0d wait=%0d want id=%0d wait=1", k, id, w, k % 4); end
            checks++; if (word !== 8'(8'h11 * (k % 4 + 1))) begin errors++;
                $display("FAIL rr_data%0d got %h want %h", k, word, 8'(8'h11 * (k % 4 + 1))); end
            finish_word(8, dv, dc, nd, ne, ec, ic, na);
            checks++; if (nd !== 1 || dv !== 4'(1 << (k % 4))) begin errors++;
                $display("FAIL rr_done%0d got n=%0d vec=%b", k, nd, dv); end
        end
        req = '0;
        tick();
    endtask

    task automatic test_wrap_skip;
        int w, dc, nd, ne, ec, ic, na;
        logic [1:0] id;
        logic [7:0] word;
        logic [3:0] av, dv;
        do_reset();
        data = 32'h44332211;
        req  = 4'b0100;
        wait_grant(6, w, id, word, av);
        req = '0;
        checks++; if (id !== 2'd2) begin errors++; $display("FAIL wrap_first got %0d want 2", id); end
        finish_word(5, dv, dc, nd, ne, ec, ic, na);
        req = 4'b0011;
        wait_grant(6, w, id, word, av);
        req = 4'b0010;
        checks++; if (id !== 2'd0 || word !== 8'h11) begin errors++;
            $display("FAIL wrap_next got id=%0d data=%h want 0/11", id, word); end
        finish_word(5, dv, dc, nd, ne, ec, ic, na);
        wait_grant(6, w, id, word, av);
        req = '0;
        checks++; if (id !== 2'd1 || word !== 8'h22) begin errors++;
            $display("FAIL wrap_then got id=%0d data=%h want 1/22", id, word); end
        finish_word(5, dv, dc, nd, ne, ec, ic, na);
        wait_grant(6, w, id, word, av);
        checks++; if (w !== -1) begin errors++; $display("FAIL wrap_extra_grant got id=%0d", id); end
    endtask

    task automatic test_watchdog;
        int w, dc, nd, ne, ec, ic, na;
        logic [1:0] id;
        logic [7:0] word;
        logic [3:0] av, dv;
        do_reset();
        data = 32'h000000A5;
        req  = 4'b0001;
        wait_grant(4, w, id, word, av);
        req = '0;
        finish_word(0, dv, dc, nd, ne, ec, ic, na);
        checks++; if (ne !== 1 || ec !== 11) begin errors++;
            $display("FAIL wdog_err got n=%0d cycle=%0d want 1/11", ne, ec); end
        checks++; if (nd !== 0) begin errors++; $display("FAIL wdog_done got %0d want 0", nd); end
        checks++; if (ic !== 12) begin errors++; $display("FAIL wdog_idle got %0d want 12", ic); end
        data = 32'h0000BB00;
        req  = 4'b0010;
        wait_grant(4, w, id, word, av);
        req = '0;
        checks++; if (id !== 2'd1 || word !== 8'hBB) begin errors++;
            $display("FAIL wdog_recover got id=%0d data=%h want 1/bb", id, word); end
        finish_word(3, dv, dc, nd, ne, ec, ic, na);
        checks++; if (nd !== 1 || ne !== 0 || dv !== 4'b0010) begin errors++;
            $display("FAIL wdog_next got done=%0d err=%0d vec=%b", nd, ne, dv); end
    endtask

    task automatic test_eos_timeout;
        int w, dc, nd, ne, ec, ic, na;
        logic [1:0] id;
        logic [7:0] word;
        logic [3:0] av, dv;
        do_reset();
        data = 32'h0000005A;
        req  = 4'b0001;
        wait_grant(4, w, id, word, av);
        req = '0;
        finish_word(TMO, dv, dc, nd, ne, ec, ic, na);
        checks++; if (nd !== 1 || dc !== 11) begin errors++;
            $display("FAIL collide_done got n=%0d cycle=%0d want 1/11", nd, dc); end
        checks++; if (ne !== 0) begin errors++; $display("FAIL collide_err got %0d want 0", ne); end
    endtask

    task automatic test_mid_reset;
        int w, nd, ne, nl;
        logic [1:0] id;
        logic [7:0] word;
        logic [3:0] av;
        do_reset();
        data = 32'h44332211;
        req  = 4'b0100;
        wait_grant(4, w, id, word, av);
        req = '0;
        for (int c = 1; c <= 3; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({busy, sh_load, err} !== 3'b0 || {ack, done} !== 8'b0) begin errors++;
            $display("FAIL mreset_outputs got busy=%b load=%b err=%b ack=%b done=%b",
                     busy, sh_load, err, ack, done); end
        checks++; if (cur_id !== 2'd0 || sh_data !== 8'h00) begin errors++;
            $display("FAIL mreset_regs got id=%0d data=%h want 0/00", cur_id, sh_data); end
        nd = 0;
        ne = 0;
        nl = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (|done) nd++;
            if (err) ne++;
            if (sh_load || busy) nl++;
        end
        checks++; if (nd !== 0 || ne !== 0 || nl !== 0) begin errors++;
            $display("FAIL mreset_quiet got done=%0d err=%0d active=%0d want 0", nd, ne, nl); end
        req = 4'b1111;
        wait_grant(4, w, id, word, av);
        req = '0;
        checks++; if (id !== 2'd0 || w !== 1) begin errors++;
            $display("FAIL mreset_first got id=%0d wait=%0d want 0/1", id, w); end
    endtask

    initial begin
        rst    = 1'b1;
        req    = '0;
        data   = '0;
        sh_eos = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap_skip();
        test_watchdog();
        test_eos_timeout();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
